// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
//   hilo_op_e    : operation encoding driven by the EX stage
//   hilo_state_e : sequencer states (idle, iterate, write-back)
//   is_signed()  : op treats its operands as two's complement
//   is_div()     : op is a divide (restoring) rather than a multiply
package hilo_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } hilo_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } hilo_state_e;

    function automatic logic is_signed(input hilo_op_e op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div(input hilo_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
//   start, op, a, b, cancel : request side (pipeline -> unit)
//   busy                    : unit occupied; pipeline stalls while high
//   lo_en/lo_d, hi_en/hi_d  : write port into lo_reg / hi_reg
// master = pipeline side, slave = the unit.
interface hilo_muldiv_unit_if
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    hilo_op_e         op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             lo_en;
    logic [WIDTH-1:0] lo_d;
    logic             hi_en;
    logic [WIDTH-1:0] hi_d;

    modport master (
        output start, op, a, b, cancel,
        input  busy, lo_en, lo_d, hi_en, hi_d
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, lo_en, lo_d, hi_en, hi_d
    );
endinterface

// File: rtl/hilo_muldiv_unit_div_step.sv
// One restoring-division step, purely combinational.
//   rem_quo      : {remainder, dividend/quotient shift register}, 2*WIDTH bits
//   divisor      : divisor magnitude
//   rem_quo_next : register contents after shifting one dividend bit into the
//                  remainder and conditionally subtracting the divisor
// The trial subtract is WIDTH+1 bits wide so the shifted-in remainder never
// truncates; bit WIDTH of the difference is the borrow.
module hilo_muldiv_unit_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rem_quo,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rem_quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_quo[2*WIDTH-1:WIDTH], rem_quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_quo_next = {diff[WIDTH-1:0], rem_quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_quo_next = {shifted[WIDTH-1:0], rem_quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine producing HI/LO results for the EX stage.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of hilo_muldiv_unit_if (start/op/a/b/cancel in,
//                busy and the lo/hi write strobes + data out)
// One op at a time: accept in IDLE, WIDTH shift-add or restoring-divide steps
// in RUN, then a single WRITE cycle pulsing lo_en/hi_en together.
// Signed ops run on magnitudes; the sign is restored on the last RUN step.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    hilo_muldiv_unit_if.slave    bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef logic [WIDTH-1:0] word_t;
    localparam word_t MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    hilo_state_e        state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_step, mul_step, div_step, prod;
    logic [WIDTH:0]     mul_sum;
    word_t              opnd, a_raw, lo_q, hi_q, lo_fix, hi_fix, quo, rem;
    word_t              mag_a, mag_b;
    logic               sign_a, sign_b;
    logic               is_div_q, neg_res, neg_rem, div_zero, div_ovf;
    logic               accept, last_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are gated by cancel/reset combinationally so a flush in the
    // WRITE cycle itself suppresses the register write.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        bus.busy   = (state != IDLE);
        bus.lo_en  = 1'b0;
        bus.hi_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    last_step  = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = IDLE;
                bus.lo_en  = !bus.cancel && !reset;
                bus.hi_en  = !bus.cancel && !reset;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand conditioning on the accept cycle.
    always_comb begin
        sign_a = is_signed(bus.op) && bus.a[WIDTH-1];
        sign_b = is_signed(bus.op) && bus.b[WIDTH-1];
        mag_a  = sign_a ? word_t'(-bus.a) : bus.a;
        mag_b  = sign_b ? word_t'(-bus.b) : bus.b;
    end

    hilo_muldiv_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_quo      (acc),
        .divisor      (opnd),
        .rem_quo_next (div_step)
    );

    // Shift-add: multiplier sits in the low half and drains out to the right
    // while the partial product grows in from the top; the carry is kept.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step = {mul_sum, acc[WIDTH-1:1]};
        acc_step = is_div_q ? div_step : mul_step;
    end

    // Sign fix and special cases, applied to the result of the final step.
    always_comb begin
        prod = neg_res ? -acc_step : acc_step;
        quo  = acc_step[WIDTH-1:0];
        rem  = acc_step[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            lo_fix = prod[WIDTH-1:0];
            hi_fix = prod[2*WIDTH-1:WIDTH];
        end else if (div_zero) begin
            lo_fix = '1;
            hi_fix = a_raw;
        end else if (div_ovf) begin
            lo_fix = a_raw;
            hi_fix = '0;
        end else begin
            lo_fix = neg_res ? word_t'(-quo) : quo;
            hi_fix = neg_rem ? word_t'(-rem) : rem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            count    <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else if (accept) begin
            is_div_q <= is_div(bus.op);
            opnd     <= is_div(bus.op) ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (is_div(bus.op) ? mag_a : mag_b)};
            a_raw    <= bus.a;
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (bus.b == '0);
            div_ovf  <= (bus.op == DIV) && (bus.a == MIN_NEG) && (bus.b == '1);
            count    <= '0;
        end else if (state == RUN && !bus.cancel) begin
            acc   <= acc_step;
            count <= count + 1'b1;
            if (last_step) begin
                lo_q <= lo_fix;
                hi_q <= hi_fix;
            end
        end
    end

    assign bus.lo_d = lo_q;
    assign bus.hi_d = hi_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit (WIDTH=32).
// A reference model computes HI/LO with native 64-bit arithmetic and tracks
// occupancy as "cycles left until the write"; a negedge process compares the
// DUT against it every cycle. Directed cases pin the model with literals.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          chk_on = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Architectural result of one op.
    function automatic void ref_op(input hilo_op_e op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        p  = '0;
        hi = '0;
        lo = '0;
        case (op)
            MULTU: begin
                p  = {32'b0, a} * {32'b0, b};
                lo = p[31:0];
                hi = p[63:32];
            end
            MULT: begin
                p  = 64'(sa * sb);
                lo = p[31:0];
                hi = p[63:32];
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = a;
                    hi = 32'd0;
                end else if (op == DIVU) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = 64'(q);
                    lo = p[31:0];
                    p  = 64'(r);
                    hi = p[31:0];
                end
            end
        endcase
    endfunction

    // Occupancy model: after an accepted op the unit is busy for W+1 cycles,
    // the last of which is the write cycle.
    int unsigned m_rem = 0;
    int unsigned m_accepts = 0;
    logic [31:0] m_lo, m_hi;

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0;
        end else if (m_rem == 0) begin
            if (bus.start && !bus.cancel) begin
                ref_op(bus.op, bus.a, bus.b, m_hi, m_lo);
                m_rem = W + 1;
                m_accepts++;
            end
        end else if (bus.cancel) begin
            m_rem = 0;
        end else begin
            m_rem--;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic exp_en;
            exp_en = (m_rem == 1) && !bus.cancel && !rst;
            chk("no_x", 64'($isunknown({bus.busy, bus.lo_en, bus.hi_en, bus.lo_d, bus.hi_d})), 64'd0);
            chk("busy", 64'(bus.busy), 64'(m_rem != 0));
            chk("lo_en", 64'(bus.lo_en), 64'(exp_en));
            chk("hi_en", 64'(bus.hi_en), 64'(exp_en));
            if (exp_en) begin
                chk("lo_d", 64'(bus.lo_d), 64'(m_lo));
                chk("hi_d", 64'(bus.hi_d), 64'(m_hi));
            end
        end
    end

    function automatic logic [31:0] rnd_word();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            4:       v = -32'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // All tasks begin and end 1ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
        chk(name, 64'(bus.busy), 64'd0);
    endtask

    task automatic directed(input string name, input hilo_op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bit seen;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.lo_en) seen = 1'b1;
        end
        chk({name, "_latency"}, 64'(n), 64'(W + 1));
        chk({name, "_hi"}, 64'(bus.hi_d), 64'(exp_hi));
        chk({name, "_lo"}, 64'(bus.lo_d), 64'(exp_lo));
        step();
        wait_idle({name, "_idle"});
    endtask

    task automatic launch(input hilo_op_e op);
        bus.op    = op;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int strobes;
        int unsigned target, cyc;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = MULT;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) step();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_lo_en", 64'(bus.lo_en), 64'd0);
        chk("rst_hi_en", 64'(bus.hi_en), 64'd0);
        chk("rst_lo_d", 64'(bus.lo_d), 64'd0);
        chk("rst_hi_d", 64'(bus.hi_d), 64'd0);
        step();
        rst = 1'b0;
        step();

        directed("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        directed("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        directed("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        directed("div_negb",  DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        directed("divu_zero", DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF);
        directed("div_zero",  DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
        directed("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);

        // Start held high: accepts at T and T+34 fall in the window, with
        // write strobes seen before T+33 and T+67.
        strobes   = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bus.op = hilo_op_e'(2'($urandom_range(0, 3)));
            bus.a  = rnd_word();
            bus.b  = rnd_word();
            @(negedge clk);
            if (bus.lo_en) strobes++;
            step();
        end
        bus.start = 1'b0;
        chk("stream_strobes", 64'(strobes), 64'd2);
        wait_idle("stream_idle");
        step();

        // Cancel in RUN at count==10.
        launch(MULTU);
        repeat (10) step();
        bus.cancel = 1'b1;
        @(negedge clk);
        chk("cancel_run_en", 64'(bus.lo_en), 64'd0);
        step();
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("cancel_run_busy", 64'(bus.busy), 64'd0);
        step();

        // Cancel in the WRITE cycle itself.
        launch(DIVU);
        repeat (W) step();
        bus.cancel = 1'b1;
        @(negedge clk);
        chk("cancel_wr_busy_pre", 64'(bus.busy), 64'd1);
        chk("cancel_wr_en", 64'(bus.hi_en), 64'd0);
        step();
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("cancel_wr_busy", 64'(bus.busy), 64'd0);
        step();

        // start together with cancel in IDLE is not accepted.
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        step();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("start_cancel_busy", 64'(bus.busy), 64'd0);
        step();

        directed("after_cancel", MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780);

        // Reset at RUN count==5 clears everything, including the data regs.
        launch(DIVU);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_lo_en", 64'(bus.lo_en), 64'd0);
        chk("midrst_hi_en", 64'(bus.hi_en), 64'd0);
        chk("midrst_lo_d", 64'(bus.lo_d), 64'd0);
        chk("midrst_hi_d", 64'(bus.hi_d), 64'd0);
        step();

        // Random mix, including starts while busy and occasional flushes.
        target = m_accepts + 1000;
        cyc    = 0;
        while (m_accepts < target && cyc < 60000) begin
            bus.start  = ($urandom_range(0, 1) == 0);
            bus.cancel = ($urandom_range(0, 149) == 0);
            bus.op     = hilo_op_e'(2'($urandom_range(0, 3)));
            bus.a      = rnd_word();
            bus.b      = rnd_word();
            step();
            cyc++;
        end
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("random_ops_done", 64'(m_accepts >= target), 64'd1);
        wait_idle("random_idle");
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
